// File: rtl/song_reader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : song_reader_pkg                                              |
// | Description : Shared widths, state encoding, end-of-song marker and the    |
// |               default song ROM image for the song_reader block.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Contents:                                                                  |
// |   NOTE_W, DUR_W, IDX_W, SONG_W  field widths                               |
// |   ADDR_W, WORD_W, ROM_DEPTH     derived ROM geometry ({song,index} -> word) |
// |   END_MARKER                    duration value that terminates a song      |
// |   state_t                       3-bit reader state encoding                |
// |   default_rom_image()           constant builder for the song ROM contents |
// +----------------------------------------------------------------------------+
package song_reader_pkg;

  localparam int NOTE_W    = 6;
  localparam int DUR_W     = 6;
  localparam int IDX_W     = 5;
  localparam int SONG_W    = 2;
  localparam int ADDR_W    = SONG_W + IDX_W;
  localparam int WORD_W    = NOTE_W + DUR_W;
  localparam int ROM_DEPTH = 1 << ADDR_W;

  // A zero duration never plays; it marks the end of a song.
  localparam logic [DUR_W-1:0] END_MARKER = '0;

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    LOAD  = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    END   = 3'd4
  } state_t;

  typedef logic [ROM_DEPTH-1:0][WORD_W-1:0] rom_image_t;

  // Default contents, word = {note, duration}, indexed by {song, index}.
  // Notes follow a simple arithmetic melody; durations cycle through 1..7.
  // Song 0 opens with note 20 for 8 beats and ends after three notes
  // (marker at index 3); song 3 ends at index 10; songs 1 and 2 use all
  // 32 slots.
  function automatic rom_image_t default_rom_image();
    rom_image_t       img;
    logic [NOTE_W-1:0] n;
    logic [DUR_W-1:0]  d;
    for (int a = 0; a < ROM_DEPTH; a++) begin
      n = NOTE_W'((a * 5 + 3) % (1 << NOTE_W));
      d = DUR_W'((a % 7) + 1);
      if (a == 0) begin
        n = NOTE_W'(20);
        d = DUR_W'(8);
      end
      if (a == 3 || a == (3 * 32 + 10)) begin
        d = END_MARKER;
      end
      img[a] = {n, d};
    end
    return img;
  endfunction

endpackage
`default_nettype wire

// File: rtl/song_reader_rom.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : song_rom                                                     |
// | Description : Synchronous 128 x 12 song ROM with a registered output.      |
// |               Contents come from the IMAGE parameter so a build can swap   |
// |               in a different song set without touching the reader.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports:                                                                     |
// |   clk   in   1       system clock                                          |
// |   addr  in   ADDR_W  {song, index}                                         |
// |   data  out  WORD_W  {note, duration}, valid one cycle after addr          |
// +----------------------------------------------------------------------------+
module song_rom
  import song_reader_pkg::*;
#(
  parameter rom_image_t IMAGE = default_rom_image()
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [WORD_W-1:0] data
);

  // No reset: the reader only consumes data one cycle after it has
  // presented a stable address, so the power-up value is never observed.
  always_ff @(posedge clk) begin
    data <= IMAGE[addr];
  end

endmodule
`default_nettype wire

// File: rtl/song_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : song_reader                                                  |
// | Description : Walks the notes of the selected song in the song ROM and     |
// |               hands each note/duration to the note player with a one-cycle |
// |               new_note pulse. Waits for note_done before advancing and     |
// |               supports skip-back (rewind) / skip-forward (ff) by SKIP      |
// |               notes. Signals end of song with a one-cycle song_done pulse. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports:                                                                     |
// |   clk        in   1       system clock                                     |
// |   reset      in   1       synchronous active-high reset                    |
// |   play       in   1       level, 1 = fetching the next note is allowed     |
// |   rewind     in   1       pulse, skip back SKIP notes (saturates at 0)     |
// |   ff         in   1       pulse, skip forward SKIP notes                   |
// |   song       in   SONG_W  selected song, stable except across reset       |
// |   note_done  in   1       pulse from note player, current note finished   |
// |   note       out  NOTE_W  registered note code                            |
// |   duration   out  DUR_W   registered duration in beats                    |
// |   new_note   out  1       pulse, note/duration valid, start playing        |
// |   song_done  out  1       pulse, end of song reached                       |
// +----------------------------------------------------------------------------+
module song_reader
  import song_reader_pkg::*;
#(
  parameter int SKIP = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic              rewind,
  input  logic              ff,
  input  logic [SONG_W-1:0] song,
  input  logic              note_done,
  output logic [NOTE_W-1:0] note,
  output logic [DUR_W-1:0]  duration,
  output logic              new_note,
  output logic              song_done
);

  localparam logic [IDX_W-1:0] LAST_INDEX = IDX_W'((1 << IDX_W) - 1);
  localparam logic [IDX_W:0]   LAST_X     = {1'b0, LAST_INDEX};
  localparam logic [IDX_W:0]   SKIP_X     = (IDX_W + 1)'(SKIP);
  localparam logic [IDX_W-1:0] SKIP_I     = IDX_W'(SKIP);

  state_t            state;
  logic [IDX_W-1:0]  index;

  logic [ADDR_W-1:0] rom_addr;
  logic [WORD_W-1:0] rom_data;
  logic [NOTE_W-1:0] rom_note;
  logic [DUR_W-1:0]  rom_dur;

  logic [IDX_W:0]    index_x;
  logic [IDX_W:0]    fwd_sum;
  logic              fwd_overflow;
  logic [IDX_W-1:0]  fwd_index;
  logic [IDX_W-1:0]  back_index;
  logic              skip_window;
  logic              skip_req;

  // ---------------------------------------------------------------------------
  // Song ROM: the address always follows {song, index}, so the word read in
  // FETCH is the one presented in LOAD.
  // ---------------------------------------------------------------------------
  assign rom_addr              = {song, index};
  assign {rom_note, rom_dur}   = rom_data;

  song_rom u_rom (
    .clk  (clk),
    .addr (rom_addr),
    .data (rom_data)
  );

  // ---------------------------------------------------------------------------
  // Skip arithmetic, one bit wider than the index so that running off the end
  // of the song is detected instead of wrapping back to the start.
  // ---------------------------------------------------------------------------
  assign index_x      = {1'b0, index};
  assign fwd_sum      = index_x + SKIP_X;
  assign fwd_overflow = (fwd_sum > LAST_X);
  assign fwd_index    = fwd_sum[IDX_W-1:0];
  assign back_index   = (index_x < SKIP_X) ? '0 : (index - SKIP_I);

  assign skip_window  = (state == FETCH) || (state == LOAD) || (state == WAIT);
  assign skip_req     = rewind | ff;

  // ---------------------------------------------------------------------------
  // Reader FSM with registered outputs.
  // A skip in FETCH/LOAD/WAIT takes priority over everything else in that
  // state: it aborts a pending LOAD (no new_note) and swallows a coincident
  // note_done, applying the move to the index as it currently stands.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      index     <= '0;
      note      <= '0;
      duration  <= '0;
      new_note  <= 1'b0;
      song_done <= 1'b0;
    end else begin
      new_note  <= 1'b0;
      song_done <= 1'b0;

      if (skip_window && skip_req) begin
        if (rewind) begin
          // rewind wins over a simultaneous ff
          index <= back_index;
          state <= FETCH;
        end else if (fwd_overflow) begin
          state     <= DONE;
          song_done <= 1'b1;
        end else begin
          index <= fwd_index;
          state <= FETCH;
        end
      end else begin
        case (state)
          FETCH: begin
            if (play) begin
              state <= LOAD;
            end
          end

          LOAD: begin
            if (rom_dur == END_MARKER) begin
              state     <= DONE;
              song_done <= 1'b1;
            end else begin
              note     <= rom_note;
              duration <= rom_dur;
              new_note <= 1'b1;
              state    <= WAIT;
            end
          end

          WAIT: begin
            // play is deliberately ignored here: pausing is the note
            // player's business, it simply withholds note_done.
            if (note_done) begin
              if (index == LAST_INDEX) begin
                state     <= DONE;
                song_done <= 1'b1;
              end else begin
                index <= index + IDX_W'(1);
                state <= FETCH;
              end
            end
          end

          // song_done is raised on entry to DONE, so DONE itself lasts one
          // cycle and then parks in END until the next reset.
          DONE: begin
            state <= END;
          end

          END: begin
            state <= END;
          end

          default: begin
            state <= FETCH;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_song_reader.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_song_reader                                               |
// | Description : Self-checking bench for song_reader: a cycle-exact vector    |
// |               table, directed end-of-song / reset sequences and randomized |
// |               episodes checked against a note-level reference model.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_song_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic       play;
  logic       rewind;
  logic       ff;
  logic [1:0] song;
  logic       note_done;
  logic [5:0] note;
  logic [5:0] duration;
  logic       new_note;
  logic       song_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  song_reader #(.SKIP(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .play      (play),
    .rewind    (rewind),
    .ff        (ff),
    .song      (song),
    .note_done (note_done),
    .note      (note),
    .duration  (duration),
    .new_note  (new_note),
    .song_done (song_done)
  );

  // ---------------------------------------------------------------------------
  // Reference: expected ROM contents and note-level index rules.
  // ---------------------------------------------------------------------------
  function automatic logic [11:0] ref_rom(input int s, input int i);
    int         a;
    logic [5:0] n;
    logic [5:0] d;
    a = s * 32 + i;
    n = 6'((a * 5 + 3) % 64);
    d = 6'((a % 7) + 1);
    if (a == 0) begin
      n = 6'd20;
      d = 6'd8;
    end
    if (a == 3 || a == 106) d = 6'd0;
    return {n, d};
  endfunction

  // New index after a skip, or -1 when the song ends.
  function automatic int ref_skip(input int idx, input bit rw, input bit f);
    if (rw) return (idx - 4 < 0) ? 0 : idx - 4;
    if (f)  return (idx + 4 > 31) ? -1 : idx + 4;
    return idx;
  endfunction

  function automatic int ref_advance(input int idx);
    return (idx == 31) ? -1 : idx + 1;
  endfunction

  // ---------------------------------------------------------------------------
  // Helpers (all start and end just after a falling edge)
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic [1:0] s);
    reset = 1'b1; play = 1'b0; rewind = 1'b0; ff = 1'b0; note_done = 1'b0;
    song = s;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse(input bit rw, input bit f, input bit nd);
    rewind = rw; ff = f; note_done = nd;
    @(negedge clk);
    rewind = 1'b0; ff = 1'b0; note_done = 1'b0;
  endtask

  // kind: 0 = nothing within the bound, 1 = new_note, 2 = song_done, 3 = both
  task automatic wait_event(output int kind, output logic [5:0] n, output logic [5:0] d);
    bit seen;
    seen = 1'b0;
    kind = 0; n = '0; d = '0;
    for (int c = 0; c < 8 && !seen; c++) begin
      if (new_note || song_done) begin
        kind = {30'd0, song_done, new_note};
        n    = note;
        d    = duration;
        seen = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic expect_note(input string name, input int s, input int i);
    int         kind;
    logic [5:0] n;
    logic [5:0] d;
    logic [11:0] e;
    e = ref_rom(s, i);
    wait_event(kind, n, d);
    check({name, " event"}, kind, 1);
    check({name, " note"}, n, e[11:6]);
    check({name, " dur"}, d, e[5:0]);
  endtask

  task automatic expect_done(input string name);
    int         kind;
    logic [5:0] n;
    logic [5:0] d;
    wait_event(kind, n, d);
    check({name, " event"}, kind, 2);
  endtask

  task automatic get_skip(output bit rw, output bit f);
    rw = 1'($urandom_range(0, 1));
    f  = rw ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Cycle-exact vector table (song 0): inputs for one edge, outputs after it.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic       rst, pl, rw, f, nd;
    logic       nn, sd;
    logic [5:0] nt, du;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic pl, input logic rw, input logic f,
                     input logic nd, input logic nn, input logic sd,
                     input logic [5:0] nt, input logic [5:0] du);
    vec_t v;
    v.rst = rst; v.pl = pl; v.rw = rw; v.f = f; v.nd = nd;
    v.nn = nn; v.sd = sd; v.nt = nt; v.du = du;
    vecs.push_back(v);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          kind;
    logic [5:0]  n;
    logic [5:0]  d;
    logic [11:0] e;

    reset = 1'b1; play = 1'b0; rewind = 1'b0; ff = 1'b0; note_done = 1'b0;
    song = 2'd0;

    //   rst pl rw ff nd   nn sd note dur
    add(1, 0, 0, 0, 0,   0, 0,  0, 0);   // reset
    add(0, 0, 0, 0, 0,   0, 0,  0, 0);   // FETCH holds with play low
    add(0, 1, 0, 0, 0,   0, 0,  0, 0);   // -> LOAD
    add(0, 1, 0, 0, 0,   1, 0, 20, 8);   // new_note two edges after play
    add(0, 1, 0, 0, 0,   0, 0, 20, 8);   // single-cycle pulse
    add(0, 1, 0, 0, 1,   0, 0, 20, 8);   // note_done -> index 1
    add(0, 0, 0, 0, 0,   0, 0, 20, 8);   // paused in FETCH
    add(0, 0, 0, 0, 0,   0, 0, 20, 8);
    add(0, 1, 0, 0, 0,   0, 0, 20, 8);
    add(0, 1, 0, 0, 0,   1, 0,  8, 2);   // ROM[1]
    add(0, 1, 0, 0, 1,   0, 0,  8, 2);   // -> index 2
    add(0, 1, 0, 0, 0,   0, 0,  8, 2);
    add(0, 1, 0, 0, 0,   1, 0, 13, 3);   // ROM[2]
    add(0, 1, 0, 1, 0,   0, 0, 13, 3);   // ff 2 -> 6
    add(0, 1, 0, 0, 0,   0, 0, 13, 3);
    add(0, 1, 0, 0, 0,   1, 0, 33, 7);   // ROM[6]
    add(0, 1, 1, 0, 0,   0, 0, 33, 7);   // rewind 6 -> 2
    add(0, 1, 0, 0, 0,   0, 0, 33, 7);
    add(0, 1, 0, 0, 0,   1, 0, 13, 3);
    add(0, 1, 1, 0, 0,   0, 0, 13, 3);   // rewind 2 -> 0 (saturates)
    add(0, 1, 0, 0, 0,   0, 0, 13, 3);
    add(0, 1, 0, 0, 0,   1, 0, 20, 8);
    add(0, 1, 0, 0, 1,   0, 0, 20, 8);   // -> 1
    add(0, 1, 0, 0, 0,   0, 0, 20, 8);
    add(0, 1, 0, 0, 0,   1, 0,  8, 2);
    add(0, 1, 0, 1, 0,   0, 0,  8, 2);   // ff 1 -> 5
    add(0, 1, 0, 0, 0,   0, 0,  8, 2);
    add(0, 1, 0, 0, 0,   1, 0, 28, 6);
    add(0, 1, 1, 1, 0,   0, 0, 28, 6);   // rewind+ff at 5 -> 1
    add(0, 1, 0, 0, 0,   0, 0, 28, 6);
    add(0, 1, 0, 0, 0,   1, 0,  8, 2);
    add(0, 1, 0, 1, 1,   0, 0,  8, 2);   // ff+note_done at 1 -> 5
    add(0, 1, 0, 0, 0,   0, 0,  8, 2);
    add(0, 1, 0, 0, 0,   1, 0, 28, 6);
    add(0, 1, 1, 0, 0,   0, 0, 28, 6);   // rewind 5 -> 1
    add(0, 1, 0, 0, 0,   0, 0, 28, 6);
    add(0, 1, 0, 0, 0,   1, 0,  8, 2);
    add(0, 1, 0, 0, 1,   0, 0,  8, 2);   // -> 2
    add(0, 1, 0, 0, 0,   0, 0,  8, 2);
    add(0, 1, 0, 0, 0,   1, 0, 13, 3);
    add(0, 1, 0, 0, 1,   0, 0, 13, 3);   // -> 3 (end marker)
    add(0, 1, 0, 0, 0,   0, 0, 13, 3);   // LOAD sees duration 0
    add(0, 1, 0, 0, 0,   0, 1, 13, 3);   // song_done, no new_note
    add(0, 1, 0, 0, 0,   0, 0, 13, 3);   // pulse is single-cycle
    add(0, 1, 0, 0, 1,   0, 0, 13, 3);   // ignored after the end
    add(0, 1, 0, 1, 0,   0, 0, 13, 3);
    add(0, 1, 1, 0, 0,   0, 0, 13, 3);
    add(0, 1, 0, 0, 0,   0, 0, 13, 3);

    @(negedge clk);
    for (int k = 0; k < vecs.size(); k++) begin
      reset = vecs[k].rst; play = vecs[k].pl; rewind = vecs[k].rw;
      ff = vecs[k].f; note_done = vecs[k].nd;
      @(negedge clk);
      check($sformatf("vec%0d new_note", k), new_note, vecs[k].nn);
      check($sformatf("vec%0d song_done", k), song_done, vecs[k].sd);
      check($sformatf("vec%0d note", k), note, vecs[k].nt);
      check($sformatf("vec%0d duration", k), duration, vecs[k].du);
    end

    // --- skip arriving while LOAD is pending aborts that fetch ---------------
    do_reset(2'd0);
    play = 1'b1;
    @(negedge clk);                       // now in LOAD for index 0
    pulse(1'b0, 1'b1, 1'b0);
    check("abort new_note", new_note, 1'b0);
    check("abort note held", note, 6'd0);
    expect_note("abort refetch", 0, 4);

    // --- ff from index 30 runs off the end ------------------------------------
    do_reset(2'd1);
    repeat (7) pulse(1'b0, 1'b1, 1'b0); // parked in FETCH: 0 -> 28
    play = 1'b1;
    expect_note("s1 i28", 1, 28);
    pulse(1'b0, 1'b0, 1'b1);
    expect_note("s1 i29", 1, 29);
    pulse(1'b0, 1'b0, 1'b1);
    expect_note("s1 i30", 1, 30);
    pulse(1'b0, 1'b1, 1'b0);
    check("ff30 new_note", new_note, 1'b0);
    expect_done("ff30 done");
    e = ref_rom(1, 30);
    check("ff30 note held", note, e[11:6]);
    check("ff30 dur held", duration, e[5:0]);
    @(negedge clk);
    check("ff30 single pulse", song_done, 1'b0);

    // --- note_done at index 31 ends the song ----------------------------------
    do_reset(2'd1);
    repeat (7) pulse(1'b0, 1'b1, 1'b0);
    play = 1'b1;
    expect_note("s1b i28", 1, 28);
    for (int i = 29; i <= 31; i++) begin
      pulse(1'b0, 1'b0, 1'b1);
      expect_note($sformatf("s1b i%0d", i), 1, i);
    end
    pulse(1'b0, 1'b0, 1'b1);
    expect_done("nd31 done");

    // --- reset while playing index 7 of song 2 --------------------------------
    do_reset(2'd2);
    pulse(1'b0, 1'b1, 1'b0);             // 0 -> 4
    play = 1'b1;
    expect_note("s2 i4", 2, 4);
    for (int i = 5; i <= 7; i++) begin
      pulse(1'b0, 1'b0, 1'b1);
      expect_note($sformatf("s2 i%0d", i), 2, i);
    end
    reset = 1'b1;
    @(negedge clk);
    check("rst note", note, 6'd0);
    check("rst dur", duration, 6'd0);
    check("rst new_note", new_note, 1'b0);
    check("rst song_done", song_done, 1'b0);
    reset = 1'b0;
    play  = 1'b1;
    @(negedge clk);
    check("rst+1 new_note", new_note, 1'b0);
    @(negedge clk);
    e = ref_rom(2, 0);
    check("rst+2 new_note", new_note, 1'b1);
    check("rst+2 note", note, e[11:6]);
    check("rst+2 dur", duration, e[5:0]);

    // --- randomized episodes against the note-level model ---------------------
    for (int ep = 0; ep < 30; ep++) begin
      int  s;
      int  idx;
      int  steps;
      int  r;
      int  act;
      bit  fin;
      bit  rw;
      bit  f;
      s = $urandom_range(0, 3);
      do_reset(2'(s));
      idx = 0; fin = 1'b0; steps = 0;
      while (!fin && steps < 25) begin
        steps++;
        r = $urandom_range(0, 5);
        if (r == 0) begin
          // skip while parked in FETCH with play low
          get_skip(rw, f);
          pulse(rw, f, 1'b0);
          idx = ref_skip(idx, rw, f);
        end else if (r == 1) begin
          // skip landing on the LOAD cycle
          play = 1'b1;
          @(negedge clk);
          get_skip(rw, f);
          pulse(rw, f, 1'b0);
          play = 1'b0;
          check($sformatf("ep%0d load-abort new_note", ep), new_note, 1'b0);
          idx = ref_skip(idx, rw, f);
        end else begin
          play = 1'b1;
          e = ref_rom(s, idx);
          wait_event(kind, n, d);
          if (e[5:0] == 6'd0) begin
            check($sformatf("ep%0d marker s%0d i%0d", ep, s, idx), kind, 2);
            fin = 1'b1;
          end else begin
            check($sformatf("ep%0d event s%0d i%0d", ep, s, idx), kind, 1);
            check($sformatf("ep%0d note i%0d", ep, idx), n, e[11:6]);
            check($sformatf("ep%0d dur i%0d", ep, idx), d, e[5:0]);
            repeat ($urandom_range(0, 3)) begin
              play = 1'($urandom_range(0, 1));
              @(negedge clk);
            end
            act = $urandom_range(0, 5);
            case (act)
              0: begin pulse(1'b0, 1'b0, 1'b1); idx = ref_advance(idx); end
              1: begin pulse(1'b1, 1'b0, 1'b0); idx = ref_skip(idx, 1'b1, 1'b0); end
              2: begin pulse(1'b0, 1'b1, 1'b0); idx = ref_skip(idx, 1'b0, 1'b1); end
              3: begin pulse(1'b1, 1'b1, 1'b0); idx = ref_skip(idx, 1'b1, 1'b1); end
              4: begin pulse(1'b0, 1'b1, 1'b1); idx = ref_skip(idx, 1'b0, 1'b1); end
              default: begin pulse(1'b1, 1'b0, 1'b1); idx = ref_skip(idx, 1'b1, 1'b0); end
            endcase
            play = 1'b0;
          end
        end
        if (!fin && idx < 0) begin
          wait_event(kind, n, d);
          check($sformatf("ep%0d end by skip/advance", ep), kind, 2);
          fin = 1'b1;
        end
      end
      if (fin) begin
        // once finished the reader stays silent
        play = 1'b1;
        @(negedge clk);
        pulse(1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check($sformatf("ep%0d idle pulses", ep), {new_note, song_done}, 2'b00);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
